// File: rtl/dot_seq_ctrl_if.sv
// Handshake bundle for dot_seq_ctrl: command, chunk stream, result.
// master drives commands/chunks and consumes results; slave is the sequencer.
interface dot_seq_ctrl_if #(
  parameter int SIZE    = 8,
  parameter int NUM     = 256,
  parameter int MAX_LEN = 64,
  parameter int OUT_W   = 32
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_W-1:0]      cmd_len;
  logic                  din_valid;
  logic                  din_ready;
  logic [NUM*SIZE-1:0]   din;
  logic                  res_valid;
  logic                  res_ready;
  logic [OUT_W-1:0]      res_data;
  logic                  res_sat;

  modport master (
    output cmd_valid, cmd_len,
    output din_valid, din,
    output res_ready,
    input  cmd_ready, din_ready,
    input  res_valid, res_data, res_sat
  );

  modport slave (
    input  cmd_valid, cmd_len,
    input  din_valid, din,
    input  res_ready,
    output cmd_ready, din_ready,
    output res_valid, res_data, res_sat
  );
endinterface

// File: rtl/dot_seq_ctrl.sv
// Long signed dot-product sequencer over a pipelined adder tree.
// Define DOT_SAT_EN to clamp res_data instead of wrapping it.
module adder_tree_s #(
  parameter int SIZE = 8,
  parameter int NUM  = 256
) (
  input  logic                              clk,
  input  logic [NUM*SIZE-1:0]               din,
  output logic signed [$clog2(NUM)+SIZE-1:0] dout
);
  localparam int TREE_W = $clog2(NUM) + SIZE;

  logic signed [TREE_W-1:0] leaf [NUM];
  logic signed [TREE_W-1:0] node [1:NUM-1];

  for (genvar i = 0; i < NUM; i++) begin : g_leaf
    assign leaf[i] = {{(TREE_W-SIZE){din[i*SIZE+SIZE-1]}},
                      din[i*SIZE +: SIZE]};
  end

  // Heap layout, one register per node; data needs no reset because
  // the sequencer's tags decide what is ever consumed.
  for (genvar n = 1; n < NUM; n++) begin : g_node
    logic signed [TREE_W-1:0] a;
    logic signed [TREE_W-1:0] b;
    if (2*n >= NUM) begin : g_bot
      assign a = leaf[2*n-NUM];
      assign b = leaf[2*n+1-NUM];
    end else begin : g_mid
      assign a = node[2*n];
      assign b = node[2*n+1];
    end
    always_ff @(posedge clk) node[n] <= a + b;
  end

  assign dout = node[1];
endmodule

module dot_seq_ctrl #(
  parameter int SIZE    = 8,
  parameter int NUM     = 256,
  parameter int MAX_LEN = 64,
  parameter int OUT_W   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dot_seq_ctrl_if.slave bus,
  output logic          busy
);
  localparam int TREE_LAT = $clog2(NUM);
  localparam int TREE_W   = TREE_LAT + SIZE;
  localparam int ACC_W    = TREE_W + $clog2(MAX_LEN) + 1;
  localparam int LEN_W    = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic v;
    logic last;
  } tag_t;

  state_t                   state;
  logic [LEN_W-1:0]         remain_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  term;
  logic signed [TREE_W-1:0] tree_dout;
  tag_t                     tag [TREE_LAT];
  tag_t                     tag_in;
  tag_t                     tag_out;
  logic                     cmd_fire;
  logic                     din_fire;
  logic                     cmd_ready_q;
  logic                     din_ready_q;
  logic                     res_valid_q;
  logic                     res_sat_q;
  logic                     busy_q;
  logic [OUT_W-1:0]         res_data_q;
  logic [OUT_W-1:0]         fmt_data;
  logic                     fmt_sat;

  adder_tree_s #(
    .SIZE (SIZE),
    .NUM  (NUM)
  ) u_tree (
    .clk  (clk),
    .din  (bus.din),
    .dout (tree_dout)
  );

  assign cmd_fire = cmd_ready_q & bus.cmd_valid;
  assign din_fire = din_ready_q & bus.din_valid;
  assign tag_in   = {din_fire,
                     din_fire & (remain_cnt == LEN_W'(1))};
  assign tag_out  = tag[TREE_LAT-1];
  assign term     = tag_out.v ? ACC_W'(tree_dout) : '0;
  assign acc_nxt  = acc + term;

  if (OUT_W >= ACC_W) begin : g_ext
    assign fmt_data = OUT_W'(acc_nxt);
    assign fmt_sat  = 1'b0;
  end else begin : g_cut
`ifdef DOT_SAT_EN
    logic [ACC_W-OUT_W:0] top;
    logic                 ovf;
    assign top = acc_nxt[ACC_W-1:OUT_W-1];
    assign ovf = (|top) & ~(&top);
    assign fmt_data = !ovf ? acc_nxt[OUT_W-1:0]
                    : acc_nxt[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                    : {1'b0, {(OUT_W-1){1'b1}}};
    assign fmt_sat  = ovf;
`else
    assign fmt_data = acc_nxt[OUT_W-1:0];
    assign fmt_sat  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      remain_cnt  <= '0;
      acc         <= '0;
      for (int i = 0; i < TREE_LAT; i++) tag[i] <= '0;
      cmd_ready_q <= 1'b0;
      din_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sat_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      tag[0] <= tag_in;
      for (int i = 1; i < TREE_LAT; i++) tag[i] <= tag[i-1];
      acc <= acc_nxt;
      unique case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            acc         <= '0;
            if (bus.cmd_len == '0) begin
              state       <= DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= '0;
              res_sat_q   <= 1'b0;
            end else begin
              state       <= RUN;
              remain_cnt  <= bus.cmd_len;
              din_ready_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (din_fire) begin
            remain_cnt <= remain_cnt - LEN_W'(1);
            if (remain_cnt == LEN_W'(1)) begin
              state       <= DRAIN;
              din_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (tag_out.v && tag_out.last) begin
            state       <= DONE;
            res_valid_q <= 1'b1;
            res_data_q  <= fmt_data;
            res_sat_q   <= fmt_sat;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.din_ready = din_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_sat   = res_sat_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Bench for dot_seq_ctrl: vector table, abort case, random commands
// against a sum-of-elements model, and an 8-bit output instance.
module tb_dot_seq_ctrl;
  localparam int TREE_LAT_A = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_a;
  logic busy_b;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dot_seq_ctrl_if #(.SIZE(8), .NUM(4), .MAX_LEN(64), .OUT_W(32)) ia ();
  dot_seq_ctrl_if #(.SIZE(8), .NUM(4), .MAX_LEN(4),  .OUT_W(8))  ib ();

  dot_seq_ctrl #(.SIZE(8), .NUM(4), .MAX_LEN(64), .OUT_W(32)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave),
    .busy  (busy_a)
  );

  dot_seq_ctrl #(.SIZE(8), .NUM(4), .MAX_LEN(4), .OUT_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave),
    .busy  (busy_b)
  );

  typedef struct {
    int          len;
    logic [31:0] chunk;
    int          gap;
    int          hold;
    longint      exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint chunk_sum(input logic [31:0] d);
    longint s;
    s = 0;
    for (int i = 0; i < 4; i++) s += longint'($signed(d[i*8 +: 8]));
    return s;
  endfunction

  // One full command on instance A; msum is the model's dot product.
  task automatic run_a(input int len, input bit rnd,
                       input logic [31:0] fixed, input int gap,
                       input int hold, output longint got,
                       output longint msum);
    int          cyc;
    int          beats;
    int          lat;
    bit          tog;
    bit          bad;
    logic        v;
    logic [31:0] d;
    logic [31:0] held;
    msum  = 0;
    beats = 0;
    tog   = 1'b1;
    bad   = 1'b0;
    cyc   = 0;
    while (!ia.cmd_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("cmd_ready_wait", longint'(ia.cmd_ready), 1);
    ia.cmd_valid = 1'b1;
    ia.cmd_len   = 7'(len);
    @(negedge clk);
    ia.cmd_valid = 1'b0;
    ia.cmd_len   = '0;
    chk("busy_after_cmd", longint'(busy_a), 1);
    cyc = 0;
    while (beats < len && cyc < 2000) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      d = rnd ? $urandom : fixed;
      ia.din_valid = v;
      ia.din       = d;
      if (ia.cmd_ready || ia.res_valid) bad = 1'b1;
      if (v && ia.din_ready) begin
        beats++;
        msum += chunk_sum(d);
      end
      @(negedge clk);
      cyc++;
    end
    chk("beats_sent", beats, len);
    ia.din_valid = 1'($urandom_range(0, 1));
    ia.din       = $urandom;
    lat = 1;
    while (!ia.res_valid && lat < 100) begin
      if (ia.din_ready || ia.cmd_ready) bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("res_latency", lat, (len == 0) ? 1 : TREE_LAT_A + 1);
    ia.din_valid = 1'b0;
    held = ia.res_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!ia.res_valid || ia.res_data !== held || ia.din_ready ||
          ia.cmd_ready || ia.res_sat)
        bad = 1'b1;
    end
    chk("handshake_rules", longint'(bad), 0);
    got = longint'($signed(ia.res_data));
    ia.res_ready = 1'b1;
    @(negedge clk);
    ia.res_ready = 1'b0;
    chk("retire_valid", longint'(ia.res_valid), 0);
    chk("retire_cmd_ready", longint'(ia.cmd_ready), 1);
    chk("retire_busy", longint'(busy_a), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint      got;
    longint      ms;
    longint      full;
    longint      exp_d;
    longint      exp_s;
    bit          bad;
    int          cyc;
    int          beats;
    logic [31:0] bd;

    tbl[0] = '{1,  32'h04030201, 0, 0,  10};
    tbl[1] = '{3,  32'h80808080, 1, 1,  -1536};
    tbl[2] = '{0,  32'h7f7f7f7f, 0, 2,  0};
    tbl[3] = '{2,  32'h7f7f7f7f, 0, 10, 1016};
    tbl[4] = '{1,  32'h01ff01ff, 2, 0,  0};
    tbl[5] = '{4,  32'hf905807f, 2, 3,  -12};
    tbl[6] = '{64, 32'h7f7f7f7f, 0, 0,  32512};
    tbl[7] = '{64, 32'h80808080, 2, 1,  -32768};

    ia.cmd_valid = 1'b0; ia.cmd_len = '0; ia.din_valid = 1'b0;
    ia.din = '0; ia.res_ready = 1'b0;
    ib.cmd_valid = 1'b0; ib.cmd_len = '0; ib.din_valid = 1'b0;
    ib.din = '0; ib.res_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", longint'(ia.cmd_ready), 0);
    chk("rst_din_ready", longint'(ia.din_ready), 0);
    chk("rst_res_valid", longint'(ia.res_valid), 0);
    chk("rst_res_data", longint'(ia.res_data), 0);
    chk("rst_res_sat", longint'(ia.res_sat), 0);
    chk("rst_busy", longint'(busy_a), 0);
    chk("rst_cmd_ready_b", longint'(ib.cmd_ready), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("cmd_ready_after_reset", longint'(ia.cmd_ready), 1);

    for (int t = 0; t < 8; t++) begin
      run_a(tbl[t].len, 1'b0, tbl[t].chunk, tbl[t].gap, tbl[t].hold, got, ms);
      chk($sformatf("vec%0d_result", t), got, tbl[t].exp);
    end

    // Abort while the only chunk is still inside the tree.
    ia.cmd_valid = 1'b1;
    ia.cmd_len   = 7'd1;
    @(negedge clk);
    ia.cmd_valid = 1'b0;
    chk("abort_din_ready", longint'(ia.din_ready), 1);
    ia.din_valid = 1'b1;
    ia.din       = 32'h7f7f7f7f;
    @(negedge clk);
    ia.din_valid = 1'b0;
    chk("abort_in_drain", longint'(ia.din_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("abort_res_valid", longint'(ia.res_valid), 0);
    chk("abort_busy", longint'(busy_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ia.res_valid) bad = 1'b1;
    end
    chk("abort_no_result", longint'(bad), 0);
    run_a(1, 1'b0, 32'h01010101, 0, 0, got, ms);
    chk("abort_clean_result", got, 4);

    for (int r = 0; r < 24; r++) begin
      run_a(int'($urandom_range(0, 8)), 1'b1, '0, 2,
            int'($urandom_range(0, 3)), got, ms);
      chk($sformatf("rand%0d_result", r), got, ms);
    end

    // 8-bit result instance: overflow in both directions.
    for (int k = 0; k < 2; k++) begin
      bd   = (k == 0) ? 32'h7f7f7f7f : 32'h80808080;
      full = 4 * chunk_sum(bd);
`ifdef DOT_SAT_EN
      exp_d = (full > 127) ? 127 : (full < -128) ? -128 : full;
      exp_s = (full > 127 || full < -128) ? 1 : 0;
`else
      exp_d = longint'($signed(8'(full)));
      exp_s = 0;
`endif
      cyc = 0;
      while (!ib.cmd_ready && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      ib.cmd_valid = 1'b1;
      ib.cmd_len   = 3'd4;
      @(negedge clk);
      ib.cmd_valid = 1'b0;
      ib.din       = bd;
      ib.din_valid = 1'b1;
      beats = 0;
      cyc   = 0;
      while (beats < 4 && cyc < 50) begin
        if (ib.din_ready) beats++;
        @(negedge clk);
        cyc++;
      end
      ib.din_valid = 1'b0;
      chk($sformatf("b%0d_beats", k), beats, 4);
      cyc = 0;
      while (!ib.res_valid && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("b%0d_res_data", k), longint'($signed(ib.res_data)), exp_d);
      chk($sformatf("b%0d_res_sat", k), longint'(ib.res_sat), exp_s);
      ib.res_ready = 1'b1;
      @(negedge clk);
      ib.res_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
